// File: rtl/sha256_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_mem_responder
// Brief    : Word-addressed memory at the far end of the SHA-256 engine's
//            memory master. It serves engine reads with a registered latency,
//            takes engine and host writes, and watches the digest region to
//            present the captured hash with a compare-against-expected flag.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_mem_responder #(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int OUT_WORDS    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  // engine port
  input  logic                    mem_we,
  input  logic [15:0]             mem_addr,
  input  logic [31:0]             mem_write_data,
  output logic [31:0]             mem_read_data,
  // host port
  input  logic                    host_we,
  input  logic [15:0]             host_addr,
  input  logic [31:0]             host_wdata,
  output logic [31:0]             host_rdata,
  // digest monitor
  input  logic [15:0]             output_addr,
  input  logic [OUT_WORDS*32-1:0] expected_hash,
  input  logic                    clear_monitor,
  output logic                    hash_valid,
  output logic [OUT_WORDS*32-1:0] hash_out,
  output logic                    hash_match,
  // sticky error flags
  output logic                    oob_err,
  output logic                    collision_err
);

  localparam int                  AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                  SW        = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam int                  HW        = OUT_WORDS * 32;
  localparam logic [16:0]         DEPTH_LIM = 17'(DEPTH);
  localparam logic [15:0]         OUT_LIM   = 16'(OUT_WORDS);
  localparam logic [OUT_WORDS-1:0] MASK_FULL = '1;

  typedef enum logic [1:0] {
    MON_IDLE    = 2'd0,
    MON_CAPTURE = 2'd1,
    MON_DONE    = 2'd2
  } mon_state_e;

  logic [31:0] mem_array [DEPTH];

  logic          eng_in_range, host_in_range, same_addr;
  logic          eng_wr, host_wr;
  logic [AW-1:0] eng_idx, host_idx;

  logic [31:0] rd_pipe_d [READ_LATENCY];
  logic [31:0] rd_pipe_q [READ_LATENCY];
  logic [31:0] host_rdata_d, host_rdata_q;
  logic        oob_err_d, oob_err_q;
  logic        collision_err_d, collision_err_q;

  logic [15:0]          region_off;
  logic                 region_hit;
  logic [SW-1:0]        slot;
  mon_state_e           mon_state_d, mon_state_q;
  logic [OUT_WORDS-1:0] mask_d, mask_q;
  logic [HW-1:0]        hash_out_d, hash_out_q;
  logic                 hash_valid_d, hash_valid_q;
  logic                 hash_match_d, hash_match_q;

  // Address qualification; the engine wins a same-address write, so the host write is suppressed.
  always_comb begin
    eng_in_range  = ({1'b0, mem_addr} < DEPTH_LIM);
    host_in_range = ({1'b0, host_addr} < DEPTH_LIM);
    eng_idx       = mem_addr[AW-1:0];
    host_idx      = host_addr[AW-1:0];
    same_addr     = (mem_addr == host_addr);
    eng_wr        = mem_we && eng_in_range;
    host_wr       = host_we && host_in_range && !(eng_wr && same_addr);
  end

  // Storage array: not reset, so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (host_wr) begin
      mem_array[host_idx] <= host_wdata;
    end
    if (eng_wr) begin
      mem_array[eng_idx] <= mem_write_data;
    end
  end

  // Read paths and sticky flags: array reads see pre-edge contents (read-first).
  always_comb begin
    rd_pipe_d[0] = eng_in_range ? mem_array[eng_idx] : '0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_pipe_d[i] = rd_pipe_q[i-1];
    end
    host_rdata_d    = host_in_range ? mem_array[host_idx] : '0;
    oob_err_d       = oob_err_q | ~eng_in_range | ~host_in_range;
    collision_err_d = collision_err_q | (eng_wr & host_we & same_addr);
  end

  // Digest monitor next state; wrapping region slots fail the mem_addr >= output_addr test.
  always_comb begin
    region_off  = mem_addr - output_addr;
    region_hit  = mem_we && (mem_addr >= output_addr) && (region_off < OUT_LIM);
    slot        = region_off[SW-1:0];
    mon_state_d = mon_state_q;
    mask_d      = mask_q;
    hash_out_d  = hash_out_q;
    if (clear_monitor) begin
      mon_state_d = MON_IDLE;
      mask_d      = '0;
      hash_out_d  = '0;
    end else begin
      if (region_hit) begin
        hash_out_d[HW-1-32*int'(slot) -: 32] = mem_write_data;
        mask_d[slot]                         = 1'b1;
      end
      case (mon_state_q)
        MON_IDLE: begin
          if (region_hit) begin
            mon_state_d = (mask_d == MASK_FULL) ? MON_DONE : MON_CAPTURE;
          end
        end
        MON_CAPTURE: begin
          if (mask_d == MASK_FULL) begin
            mon_state_d = MON_DONE;
          end
        end
        MON_DONE: begin
          mon_state_d = MON_DONE;
        end
        default: begin
          mon_state_d = MON_IDLE;
        end
      endcase
    end
    hash_valid_d = (mon_state_d == MON_DONE);
    hash_match_d = hash_valid_d && (hash_out_d == expected_hash);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_pipe_q[i] <= '0;
      end
      host_rdata_q    <= '0;
      oob_err_q       <= 1'b0;
      collision_err_q <= 1'b0;
      mon_state_q     <= MON_IDLE;
      mask_q          <= '0;
      hash_out_q      <= '0;
      hash_valid_q    <= 1'b0;
      hash_match_q    <= 1'b0;
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_pipe_q[i] <= rd_pipe_d[i];
      end
      host_rdata_q    <= host_rdata_d;
      oob_err_q       <= oob_err_d;
      collision_err_q <= collision_err_d;
      mon_state_q     <= mon_state_d;
      mask_q          <= mask_d;
      hash_out_q      <= hash_out_d;
      hash_valid_q    <= hash_valid_d;
      hash_match_q    <= hash_match_d;
    end
  end

  assign mem_read_data = rd_pipe_q[READ_LATENCY-1];
  assign host_rdata    = host_rdata_q;
  assign oob_err       = oob_err_q;
  assign collision_err = collision_err_q;
  assign hash_valid    = hash_valid_q;
  assign hash_out      = hash_out_q;
  assign hash_match    = hash_match_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_mem_responder
// Brief    : Bench for sha256_mem_responder. Two instances (read latency 1
//            and 3) share stimulus; a memory/digest model predicts outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_mem_responder;

  localparam int DEPTH = 1024;
  localparam logic [255:0] ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data;
  logic         host_we;
  logic [15:0]  host_addr;
  logic [31:0]  host_wdata;
  logic [15:0]  output_addr;
  logic [255:0] expected_hash;
  logic         clear_monitor;

  logic [31:0]  rd1, rd3, hrd1, hrd3;
  logic         hv1, hv3, hm1, hm3, oob1, oob3, col1, col3;
  logic [255:0] ho1, ho3;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  sha256_mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(1), .OUT_WORDS(8)) u_dut1 (
    .clk(clk), .reset(reset),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(rd1),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(hrd1),
    .output_addr(output_addr), .expected_hash(expected_hash), .clear_monitor(clear_monitor),
    .hash_valid(hv1), .hash_out(ho1), .hash_match(hm1), .oob_err(oob1), .collision_err(col1)
  );

  sha256_mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(3), .OUT_WORDS(8)) u_dut3 (
    .clk(clk), .reset(reset),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(rd3),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(hrd3),
    .output_addr(output_addr), .expected_hash(expected_hash), .clear_monitor(clear_monitor),
    .hash_valid(hv3), .hash_out(ho3), .hash_match(hm3), .oob_err(oob3), .collision_err(col3)
  );

  // ---------------- reference model ----------------
  logic [31:0]  m_mem [DEPTH];
  bit           m_kn  [DEPTH];
  logic [31:0]  m_rd  [4];     // m_rd[k]: expected read data for latency k+1
  bit           m_rdk [4];
  logic [31:0]  m_hrd;
  bit           m_hrdk = 0;
  bit           m_oob = 0, m_col = 0, m_valid = 0, m_match = 0;
  logic [7:0]   m_mask = '0;
  logic [31:0]  m_slot [8];
  logic [255:0] m_digest = '0;

  initial begin
    for (int i = 0; i < 4; i++) begin m_rd[i] = '0; m_rdk[i] = 0; end
    for (int i = 0; i < 8; i++) m_slot[i] = '0;
  end

  // Model update on every active edge, driven only by the stimulus.
  always @(posedge clk) begin : model
    logic [31:0] rv;
    bit          rk;
    bit          eng_ok, host_ok;
    int          off;
    rk = (mem_addr >= DEPTH) ? 1'b1 : m_kn[mem_addr];
    rv = (mem_addr >= DEPTH) ? 32'h0 : m_mem[mem_addr];
    for (int i = 3; i > 0; i--) begin m_rd[i] = m_rd[i-1]; m_rdk[i] = m_rdk[i-1]; end
    m_rd[0] = rv; m_rdk[0] = rk;
    m_hrdk  = (host_addr >= DEPTH) ? 1'b1 : m_kn[host_addr];
    m_hrd   = (host_addr >= DEPTH) ? 32'h0 : m_mem[host_addr];
    eng_ok  = mem_we && (mem_addr < DEPTH);
    host_ok = host_we && (host_addr < DEPTH) && !(eng_ok && host_addr == mem_addr);
    if (host_ok) begin m_mem[host_addr] = host_wdata; m_kn[host_addr] = 1; end
    if (eng_ok)  begin m_mem[mem_addr] = mem_write_data; m_kn[mem_addr] = 1; end
    m_oob = m_oob || (mem_addr >= DEPTH) || (host_addr >= DEPTH);
    m_col = m_col || (eng_ok && host_we && host_addr == mem_addr);
    off   = int'(mem_addr) - int'(output_addr);
    if (clear_monitor) begin
      m_mask = '0;
      for (int k = 0; k < 8; k++) m_slot[k] = '0;
    end else if (mem_we && off >= 0 && off < 8) begin
      m_slot[off] = mem_write_data;
      m_mask[off] = 1'b1;
    end
    if (reset) begin
      for (int i = 0; i < 4; i++) begin m_rd[i] = '0; m_rdk[i] = 1; end
      m_hrd = '0; m_hrdk = 1; m_oob = 0; m_col = 0; m_mask = '0;
      for (int k = 0; k < 8; k++) m_slot[k] = '0;
    end
    for (int k = 0; k < 8; k++) m_digest[255-32*k -: 32] = m_slot[k];
    m_valid = (m_mask == 8'hFF);
    m_match = m_valid && (m_digest == expected_hash);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_rdk[0]) check("rd_lat1", 256'(rd1), 256'(m_rd[0]));
      if (m_rdk[2]) check("rd_lat3", 256'(rd3), 256'(m_rd[2]));
      if (m_hrdk) begin
        check("host_rd_1", 256'(hrd1), 256'(m_hrd));
        check("host_rd_3", 256'(hrd3), 256'(m_hrd));
      end
      check("valid_1", 256'(hv1), 256'(m_valid));
      check("valid_3", 256'(hv3), 256'(m_valid));
      check("hash_1", ho1, m_digest);
      check("hash_3", ho3, m_digest);
      check("match_1", 256'(hm1), 256'(m_match));
      check("match_3", 256'(hm3), 256'(m_match));
      check("oob_1", 256'(oob1), 256'(m_oob));
      check("oob_3", 256'(oob3), 256'(m_oob));
      check("coll_1", 256'(col1), 256'(m_col));
      check("coll_3", 256'(col3), 256'(m_col));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic eng_write(input logic [15:0] a, input logic [31:0] d);
    mem_we = 1; mem_addr = a; mem_write_data = d;
    tick();
    mem_we = 0;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 16'($urandom_range(0, 31));
      4, 5, 6, 7: return output_addr + 16'($urandom_range(0, 9));
      8:          return 16'(DEPTH + $urandom_range(0, 7));
      default:    return 16'hFFFF - 16'($urandom_range(0, 3));
    endcase
  endfunction

  logic [31:0] abc_w [8];
  int          ord   [9];
  logic [15:0] oa_list [3];

  initial begin
    for (int k = 0; k < 8; k++) begin
      logic [255:0] t;
      t = ABC;
      abc_w[k] = t[255-32*k -: 32];
    end
    ord     = '{7, 3, 0, 1, 2, 3, 4, 5, 6};
    oa_list = '{16'h0100, 16'h0108, 16'hFFFC};

    reset = 1; mem_we = 0; mem_addr = 0; mem_write_data = 0;
    host_we = 0; host_addr = 0; host_wdata = 0;
    output_addr = 16'h0100; expected_hash = ABC; clear_monitor = 0;
    tick(); tick(); tick();
    chk_en = 1;
    check("reset_rd", 256'(rd1), 256'h0);
    check("reset_valid", 256'(hv1), 256'h0);
    check("reset_hash", ho1, 256'h0);
    check("reset_oob", 256'(oob1), 256'h0);
    reset = 0;

    // Preload 0..19 with known pattern, 20..63 random.
    host_we = 1;
    for (int n = 0; n < 64; n++) begin
      host_addr  = 16'(n);
      host_wdata = (n < 20) ? 32'h0100_0000 + 32'(n) : $urandom;
      tick();
    end
    host_we = 0; host_addr = 16'd3;

    mem_addr = 16'd5; tick();
    check("rd1_addr5", 256'(rd1), 256'h0100_0005);
    check("host_addr3", 256'(hrd1), 256'h0100_0003);
    mem_addr = 16'd6; tick();
    check("rd1_addr6", 256'(rd1), 256'h0100_0006);
    mem_addr = 16'd7; tick();
    check("rd1_addr7", 256'(rd1), 256'h0100_0007);
    check("rd3_addr5", 256'(rd3), 256'h0100_0005);
    mem_addr = 16'd8; tick();
    check("rd3_addr6", 256'(rd3), 256'h0100_0006);
    tick();
    check("rd3_addr7", 256'(rd3), 256'h0100_0007);

    // In-order digest capture of SHA-256("abc").
    for (int k = 0; k < 8; k++) begin
      eng_write(16'h0100 + 16'(k), abc_w[k]);
      if (k == 6) check("valid_before_8th", 256'(hv1), 256'h0);
    end
    check("abc_valid", 256'(hv1), 256'h1);
    check("abc_match", 256'(hm1), 256'h1);
    check("abc_hash", ho1, ABC);

    // Clear in DONE coinciding with a hit.
    clear_monitor = 1;
    eng_write(16'h0100, 32'h1234_5678);
    clear_monitor = 0;
    check("clr_valid", 256'(hv1), 256'h0);
    check("clr_hash", ho1, 256'h0);

    // Out-of-order capture with slot 3 overwritten.
    for (int i = 0; i < 9; i++) begin
      eng_write(16'h0100 + 16'(ord[i]), (i == 5) ? 32'hDEAD_BEEF : abc_w[ord[i]]);
      if (i == 7) check("ooo_valid_early", 256'(hv1), 256'h0);
    end
    check("ooo_valid", 256'(hv1), 256'h1);
    check("ooo_word3", 256'(ho1[255-96 -: 32]), 256'hDEAD_BEEF);
    check("ooo_match", 256'(hm1), 256'h0);

    // Collision on address 10.
    mem_we = 1; host_we = 1; mem_addr = 16'd10; host_addr = 16'd10;
    mem_write_data = 32'h2222_2222; host_wdata = 32'h1111_1111;
    tick();
    mem_we = 0; host_we = 0;
    check("coll_flag", 256'(col1), 256'h1);
    tick();
    check("coll_rd", 256'(rd1), 256'h2222_2222);
    check("coll_hrd", 256'(hrd1), 256'h2222_2222);

    // Out-of-range read and writes.
    host_addr = 16'd0;
    mem_addr = 16'd1024; tick();
    check("oob_rd", 256'(rd1), 256'h0);
    check("oob_flag", 256'(oob1), 256'h1);
    host_we = 1; host_addr = 16'hFFFF; host_wdata = 32'hCAFE_0001;
    eng_write(16'hFFFF, 32'hCAFE_0002);
    host_we = 0; host_addr = 16'd0;
    for (int n = 0; n < 20; n++) begin mem_addr = 16'(n); tick(); end

    // Reset during capture with 4 slots set.
    clear_monitor = 1; tick(); clear_monitor = 0;
    for (int k = 0; k < 4; k++) eng_write(16'h0100 + 16'(k), abc_w[k]);
    reset = 1; tick(); reset = 0;
    check("rst_oob", 256'(oob1), 256'h0);
    check("rst_coll", 256'(col1), 256'h0);
    for (int k = 4; k < 8; k++) eng_write(16'h0100 + 16'(k), abc_w[k]);
    check("rst_mask_cleared", 256'(hv1), 256'h0);
    mem_addr = 16'd5; tick();
    check("rst_persist", 256'(rd1), 256'h0100_0005);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) output_addr = oa_list[$urandom_range(0, 2)];
      mem_we         = 1'($urandom_range(0, 1));
      mem_addr       = pick_addr();
      mem_write_data = $urandom;
      host_we        = ($urandom_range(0, 3) == 0);
      host_addr      = pick_addr();
      host_wdata     = $urandom;
      clear_monitor  = ($urandom_range(0, 59) == 0);
      reset          = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 3) == 0) expected_hash = m_digest;
      else if ($urandom_range(0, 7) == 0) expected_hash = {8{$urandom}};
      tick();
    end
    reset = 0; mem_we = 0; host_we = 0; clear_monitor = 0;
    mem_addr = 16'd0; host_addr = 16'd0;
    tick(); tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
